// File: rtl/status_sequencer_pkg.sv
// status_sequencer_pkg: shared state indices and reset vector for the phase sequencer
package status_sequencer_pkg;
    localparam int S_IF0 = 0;
    localparam int S_IF1 = 1;
    localparam int S_FF0 = 2;
    localparam int S_FF1 = 3;
    localparam int S_FF2 = 4;
    localparam int S_TF0 = 5;
    localparam int S_TF1 = 6;
    localparam int S_EX0 = 7;
    localparam int S_EX1 = 8;
    localparam int S_IT0 = 9;
    localparam logic [63:0] RST_STATE = 64'd1 << S_IF0;
    function automatic int nstate(input int it_len);
        return S_IT0 + it_len;
    endfunction
endpackage

// File: rtl/status_sequencer_ack_wait_timer.sv
// status_sequencer_ack_wait_timer: counts FF1 wait cycles and flags the last allowed one
module status_sequencer_ack_wait_timer #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expire
);
    localparam int CW = ACK_TIMEOUT > 0 ? $clog2(ACK_TIMEOUT + 1) : 1;
    logic [CW-1:0] r_count;
    // clear wins over run so the count is zero in every non-FF1 cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      r_count <= '0;
        else if (clear) r_count <= '0;
        else if (run)   r_count <= r_count + 1'b1;
    end
    assign expire = (ACK_TIMEOUT != 0) && (r_count == CW'(ACK_TIMEOUT - 1));
endmodule

// File: rtl/status_sequencer.sv
// status_sequencer: one-hot CPU phase sequencer with interrupt, stall, ACK timeout and state recovery
module status_sequencer
    import status_sequencer_pkg::*;
#(
    parameter int IT_LEN      = 3,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ITA,
    input  logic              ACK,
    input  logic              FROM_D,
    input  logic              TO_D,
    input  logic              STALL,
    output logic              IF0,
    output logic              IF1,
    output logic              FF0,
    output logic              FF1,
    output logic              FF2,
    output logic              TF0,
    output logic              TF1,
    output logic              EX0,
    output logic              EX1,
    output logic [IT_LEN-1:0] IT,
    output logic              BUS_ERR,
    output logic              ILLEGAL
);
    localparam int NSTATE = nstate(IT_LEN);
    localparam logic [NSTATE-1:0] RST_VEC = RST_STATE[NSTATE-1:0];
    logic [NSTATE-1:0] r_state, w_next, w_state_d;
    logic r_bus_err, r_illegal, w_onehot, w_expire, w_timeout;
    assign w_onehot  = $onehot(r_state);
    assign w_timeout = r_state[S_FF1] & ~ACK & w_expire;
    // one-hot next-state: each bit ORs the transitions that lead into it
    always_comb begin
        w_next         = '0;
        w_next[S_IF0]  = (r_state[S_EX0] & TO_D) | r_state[S_EX1] | r_state[NSTATE-1];
        w_next[S_IF1]  = r_state[S_IF0] & ~ITA;
        w_next[S_FF0]  = r_state[S_IF1];
        w_next[S_FF1]  = (r_state[S_FF0] & ~FROM_D) | (r_state[S_FF1] & ~ACK & ~w_expire);
        w_next[S_FF2]  = (r_state[S_FF0] & FROM_D) | (r_state[S_FF1] & ACK);
        w_next[S_TF0]  = r_state[S_FF2];
        w_next[S_TF1]  = r_state[S_TF0] & ~TO_D;
        w_next[S_EX0]  = (r_state[S_TF0] & TO_D) | r_state[S_TF1];
        w_next[S_EX1]  = r_state[S_EX0] & ~TO_D;
        w_next[S_IT0]  = (r_state[S_IF0] & ITA) | w_timeout;
        for (int k = 1; k < IT_LEN; k++) w_next[S_IT0+k] = r_state[S_IT0+k-1];
    end
    // recovery overrides STALL; the timer clears whenever the loaded state is not FF1
    assign w_state_d = !w_onehot ? RST_VEC : STALL ? r_state : w_next;
    status_sequencer_ack_wait_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
        .clk   (clk),
        .reset (reset),
        .run   (r_state[S_FF1] & ~STALL & ~ACK),
        .clear (~w_state_d[S_FF1]),
        .expire(w_expire)
    );
    // state, bus-error flag and illegal-state pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= RST_VEC;
            r_bus_err <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_illegal <= ~w_onehot;
            r_bus_err <= !w_onehot ? 1'b0 : STALL ? r_bus_err : w_timeout;
        end
    end
    assign IF0     = r_state[S_IF0];
    assign IF1     = r_state[S_IF1];
    assign FF0     = r_state[S_FF0];
    assign FF1     = r_state[S_FF1];
    assign FF2     = r_state[S_FF2];
    assign TF0     = r_state[S_TF0];
    assign TF1     = r_state[S_TF1];
    assign EX0     = r_state[S_EX0];
    assign EX1     = r_state[S_EX1];
    assign IT      = r_state[NSTATE-1:S_IT0];
    assign BUS_ERR = r_bus_err;
    assign ILLEGAL = r_illegal;
endmodule

// File: tb/tb_status_sequencer.sv
// tb_status_sequencer: directed phase-sequence checks for status_sequencer
module tb_status_sequencer;
    localparam int IT_LEN = 5;
    localparam int AT     = 4;
    localparam int P_IF0 = 0, P_IF1 = 1, P_FF0 = 2, P_FF1 = 3, P_FF2 = 4;
    localparam int P_TF0 = 5, P_TF1 = 6, P_EX0 = 7, P_EX1 = 8, P_IT0 = 9;
    logic clk = 1'b0, reset = 1'b1;
    logic ITA = 1'b0, ACK = 1'b0, FROM_D = 1'b0, TO_D = 1'b0, STALL = 1'b0;
    logic IF0, IF1, FF0, FF1, FF2, TF0, TF1, EX0, EX1, BUS_ERR, ILLEGAL;
    logic [IT_LEN-1:0] IT;
    logic [9+IT_LEN-1:0] ph;
    int n_cmp = 0, n_err = 0;
    status_sequencer #(.IT_LEN(IT_LEN), .ACK_TIMEOUT(AT)) dut (
        .clk(clk), .reset(reset), .ITA(ITA), .ACK(ACK), .FROM_D(FROM_D), .TO_D(TO_D), .STALL(STALL),
        .IF0(IF0), .IF1(IF1), .FF0(FF0), .FF1(FF1), .FF2(FF2), .TF0(TF0), .TF1(TF1), .EX0(EX0), .EX1(EX1),
        .IT(IT), .BUS_ERR(BUS_ERR), .ILLEGAL(ILLEGAL)
    );
    assign ph = {IT, EX1, EX0, TF1, TF0, FF2, FF1, FF0, IF1, IF0};
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask
    task automatic ex(input string tag, input int idx, input logic be);
        chk({tag, "_phase"}, 32'(ph), 32'd1 << idx);
        chk({tag, "_buserr"}, 32'(BUS_ERR), 32'(be));
        chk({tag, "_illegal"}, 32'(ILLEGAL), 32'd0);
        @(negedge clk);
    endtask
    task automatic cnt(input string tag, input int v);
        chk({tag, "_count"}, 32'(dut.u_timer.r_count), 32'(v));
    endtask
    initial begin
        @(negedge clk);
        chk("rst_phase", 32'(ph), 32'd1);
        chk("rst_buserr", 32'(BUS_ERR), 32'd0);
        chk("rst_illegal", 32'(ILLEGAL), 32'd0);
        cnt("rst", 0);
        reset = 1'b0;
        FROM_D = 1'b1; TO_D = 1'b1;
        ex("min_if0", P_IF0, 0); ex("min_if1", P_IF1, 0); ex("min_ff0", P_FF0, 0);
        ex("min_ff2", P_FF2, 0); ex("min_tf0", P_TF0, 0); ex("min_ex0", P_EX0, 0);
        ex("min_if0b", P_IF0, 0);
        FROM_D = 1'b0; TO_D = 1'b0;
        ex("max_if1", P_IF1, 0); ex("max_ff0", P_FF0, 0);
        cnt("max_w0", 0); ex("max_ff1a", P_FF1, 0);
        cnt("max_w1", 1); ex("max_ff1b", P_FF1, 0);
        ACK = 1'b1;
        cnt("max_w2", 2); ex("max_ff1c", P_FF1, 0);
        ACK = 1'b0;
        cnt("max_ff2", 0);
        ex("max_ff2", P_FF2, 0); ex("max_tf0", P_TF0, 0); ex("max_tf1", P_TF1, 0);
        ex("max_ex0", P_EX0, 0); ex("max_ex1", P_EX1, 0); ex("max_if0", P_IF0, 0);
        ex("to_if1", P_IF1, 0); ex("to_ff0", P_FF0, 0);
        ex("to_ff1a", P_FF1, 0); ex("to_ff1b", P_FF1, 0); ex("to_ff1c", P_FF1, 0);
        cnt("to_w3", 3); ex("to_ff1d", P_FF1, 0);
        cnt("to_it0", 0);
        ex("to_it0", P_IT0, 1); ex("to_it1", P_IT0 + 1, 0); ex("to_it2", P_IT0 + 2, 0);
        ex("to_it3", P_IT0 + 3, 0); ex("to_it4", P_IT0 + 4, 0); ex("to_if0", P_IF0, 0);
        ex("ak_if1", P_IF1, 0); ex("ak_ff0", P_FF0, 0);
        ex("ak_ff1a", P_FF1, 0); ex("ak_ff1b", P_FF1, 0);
        STALL = 1'b1;
        cnt("ak_st0", 2); ex("ak_ff1s0", P_FF1, 0);
        cnt("ak_st1", 2); ex("ak_ff1s1", P_FF1, 0);
        STALL = 1'b0;
        cnt("ak_w2", 2); ex("ak_ff1c", P_FF1, 0);
        ACK = 1'b1;
        cnt("ak_w3", 3); ex("ak_ff1d", P_FF1, 0);
        ACK = 1'b0;
        ex("ak_ff2", P_FF2, 0); ex("ak_tf0", P_TF0, 0); ex("ak_tf1", P_TF1, 0);
        ex("ak_ex0", P_EX0, 0); ex("ak_ex1", P_EX1, 0);
        ITA = 1'b1;
        ex("it_if0", P_IF0, 0);
        ITA = 1'b0;
        ex("it_it0", P_IT0, 0); ex("it_it1", P_IT0 + 1, 0);
        STALL = 1'b1;
        ex("it_it2s0", P_IT0 + 2, 0); ex("it_it2s1", P_IT0 + 2, 0);
        STALL = 1'b0;
        ex("it_it2", P_IT0 + 2, 0); ex("it_it3", P_IT0 + 3, 0); ex("it_it4", P_IT0 + 4, 0);
        ex("it_if0b", P_IF0, 0);
        force dut.r_state = '0;
        release dut.r_state;
        @(negedge clk);
        chk("zero_phase", 32'(ph), 32'd1);
        chk("zero_illegal", 32'(ILLEGAL), 32'd1);
        @(negedge clk);
        chk("zero_phase2", 32'(ph), 32'd1 << P_IF1);
        chk("zero_illegal2", 32'(ILLEGAL), 32'd0);
        force dut.r_state = 14'b00000000011000;
        release dut.r_state;
        @(negedge clk);
        chk("two_phase", 32'(ph), 32'd1);
        chk("two_illegal", 32'(ILLEGAL), 32'd1);
        cnt("two", 0);
        @(negedge clk);
        chk("two_phase2", 32'(ph), 32'd1 << P_IF1);
        chk("two_illegal2", 32'(ILLEGAL), 32'd0);
        ex("ar_if1", P_IF1, 0); ex("ar_ff0", P_FF0, 0);
        ex("ar_ff1a", P_FF1, 0); ex("ar_ff1b", P_FF1, 0);
        cnt("ar_pre", 2);
        #2 reset = 1'b1;
        #1;
        chk("ar_phase", 32'(ph), 32'd1);
        cnt("ar_post", 0);
        chk("ar_buserr", 32'(BUS_ERR), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ex("ar_if0", P_IF0, 0);
        ex("ar_if1b", P_IF1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
